i2c_link: RTL and testbench

I2C_LINK -- requirements
Module: i2c_link

---
 rtl/i2c_link.sv | 340 ++++++++++++++++++++++++++++++++++
 tb/tb_i2c_link.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_link.sv
// i2c_link: single-master I2C link with an embedded slave on the same SDA/SCL pair.
//   pulse_generator - turns the level request `send` into one 1-clk start pulse per rising edge.
//   i2c_master      - START, address frame, NUM_OF_FRAMES-1 data frames, ACK sampling, STOP.
//   i2c_slave       - START/STOP detection, address match, ACK drive and byte capture.
// Top ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   send           in   level request; a transaction starts on its rising edge
//   addr2send[6:0] in   target address
//   r_or_w         in   R/W bit appended to the address (0 = write)
//   data2send[7:0] in   byte sent in every data frame
//   scl            out  I2C clock
//   sda            io   I2C data, open-drain (released = weak pull-up)
//   data_received  out  last byte captured by the slave
//   busy           out  high from START until STOP completes

// Start-pulse generator: one registered 1-clk pulse per 0->1 edge of send_i.
module pulse_generator (
  input  logic clk_i,
  input  logic rst_i,
  input  logic send_i,
  output logic pulse_o
);
  logic send_q, pulse_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      send_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      send_q  <= send_i;
      pulse_q <= send_i & ~send_q;
    end
  end

  assign pulse_o = pulse_q;
endmodule

// Master: each bit lasts 2*SCL_HALF clk (scl low half, then high half). SDA is held in a
// register that only moves at the middle of the scl-low half, so it never changes while scl=1
// except for the deliberate START/STOP transitions.
module i2c_master #(
  parameter int unsigned NUM_OF_FRAMES = 2,
  parameter int unsigned SCL_HALF      = 50
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pulse_i,
  input  logic [6:0] addr_i,
  input  logic       rw_i,
  input  logic [7:0] data_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_low_o,
  output logic       busy_o
);
  localparam int unsigned BitLen = 2 * SCL_HALF;
  localparam int unsigned CntW   = $clog2(BitLen);
  localparam int unsigned FrW    = (NUM_OF_FRAMES > 1) ? $clog2(NUM_OF_FRAMES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BitLen - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(SCL_HALF);
  localparam logic [CntW-1:0] CntMid  = CntW'(SCL_HALF / 2);
  localparam logic [FrW-1:0]  FrLast  = FrW'(NUM_OF_FRAMES - 1);

  typedef enum logic [2:0] {StIdle, StStart, StBit, StAck, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [FrW-1:0]  frame_q, frame_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      data_q, data_d;
  logic            nack_q, nack_d;
  logic            sda_low_q, sda_low_d;
  logic            bit_end;

  assign bit_end = (cnt_q == CntLast);

  // State register and datapath.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      frame_q   <= '0;
      sh_q      <= '0;
      data_q    <= '0;
      nack_q    <= 1'b0;
      sda_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      frame_q   <= frame_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
      nack_q    <= nack_d;
      sda_low_q <= sda_low_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    bit_d   = bit_q;
    frame_d = frame_q;
    sh_d    = sh_q;
    data_d  = data_q;
    nack_d  = nack_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (pulse_i) begin
          state_d = StStart;
          sh_d    = {addr_i, rw_i};
          data_d  = data_i;
          bit_d   = '0;
          frame_d = '0;
          nack_d  = 1'b0;
        end
      end
      StStart: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = StBit;
        end
      end
      StBit: begin
        if (bit_end) begin
          cnt_d = '0;
          sh_d  = {sh_q[6:0], 1'b0};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StAck;
        end
      end
      StAck: begin
        if (cnt_q == CntHalf) nack_d = sda_i;  // sampled on the scl rising edge
        if (bit_end) begin
          cnt_d = '0;
          if (nack_q || frame_q == FrLast) begin
            state_d = StStop;
          end else begin
            frame_d = frame_q + FrW'(1);
            sh_d    = data_q;
            state_d = StBit;
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    scl_o     = 1'b1;
    busy_o    = 1'b1;
    sda_low_d = sda_low_q;
    unique case (state_q)
      StIdle: begin
        busy_o    = 1'b0;
        sda_low_d = pulse_i;  // START: sda falls while scl stays high
      end
      StStart: sda_low_d = 1'b1;
      StBit: begin
        scl_o = (cnt_q >= CntHalf);
        if (cnt_q == CntMid) sda_low_d = ~sh_q[7];
      end
      StAck: begin
        scl_o = (cnt_q >= CntHalf);
        if (cnt_q == CntMid) sda_low_d = 1'b0;
      end
      StStop: begin
        scl_o = (cnt_q >= CntHalf);
        if (cnt_q == CntMid) sda_low_d = 1'b1;
        // Release after SCL_HALF clk of scl high: the STOP edge.
        if (bit_end) sda_low_d = 1'b0;
      end
      default: sda_low_d = 1'b0;
    endcase
  end

  assign sda_low_o = sda_low_q;
endmodule

// Slave: scl/sda pass through a 2-flop synchroniser; edges are taken between its two stages.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDRESS = 7'h50
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_low_o,
  output logic [7:0] data_o
);
  typedef enum logic [2:0] {SlIdle, SlRecv, SlAckWait, SlAckDrive, SlIgnore} state_e;

  state_e     state_q, state_d;
  logic [1:0] scl_sync_q, sda_sync_q;  // [0] newest, [1] previous
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] sh_q, sh_d;
  logic       first_q, first_d;
  logic [7:0] data_q, data_d;
  logic       scl_rise, scl_fall, start_det, stop_det, sda_bit;

  assign sda_bit   = sda_sync_q[0];
  assign scl_rise  = (scl_sync_q == 2'b01);
  assign scl_fall  = (scl_sync_q == 2'b10);
  assign start_det = (scl_sync_q == 2'b11) && (sda_sync_q == 2'b10);
  assign stop_det  = (scl_sync_q == 2'b11) && (sda_sync_q == 2'b01);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      state_q    <= SlIdle;
      cnt_q      <= '0;
      sh_q       <= '0;
      first_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      first_q    <= first_d;
      data_q     <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    first_d = first_q;
    data_d  = data_q;
    if (stop_det) begin
      state_d = SlIdle;
    end else if (start_det) begin
      state_d = SlRecv;
      cnt_d   = '0;
      first_d = 1'b1;
    end else begin
      unique case (state_q)
        SlIdle, SlIgnore: ;
        SlRecv: begin
          if (scl_rise) begin
            sh_d  = {sh_q[5:0], sda_bit};
            cnt_d = cnt_q + 3'd1;  // wraps to 0 after the 8th bit
            if (cnt_q == 3'd7) begin
              first_d = 1'b0;
              if (!first_q) begin
                data_d  = {sh_q, sda_bit};
                state_d = SlAckWait;
              end else if (sh_q == SLAVE_ADDRESS) begin
                state_d = SlAckWait;  // sh_q holds the address, sda_bit is R/W
              end else begin
                state_d = SlIgnore;
              end
            end
          end
        end
        // Drive ACK from the scl fall after bit 8 to the scl fall after the ACK bit.
        SlAckWait:  if (scl_fall) state_d = SlAckDrive;
        SlAckDrive: if (scl_fall) state_d = SlRecv;
        default:    state_d = SlIdle;
      endcase
    end
  end

  always_comb begin
    sda_low_o = (state_q == SlAckDrive);
    data_o    = data_q;
  end
endmodule

module i2c_link #(
  parameter int unsigned NUM_OF_FRAMES = 2,
  parameter logic [6:0]  SLAVE_ADDRESS = 7'h50,
  parameter int unsigned SCL_HALF      = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [6:0] addr2send,
  input  logic       r_or_w,
  input  logic [7:0] data2send,
  output logic       scl,
  inout  wire        sda,
  output logic [7:0] data_received,
  output logic       busy
);
  logic pulse, m_sda_low, s_sda_low, sda_line;

  // Both ends sit on this die, so the resolved line is the wired-AND of the two open drains.
  assign sda_line = ~(m_sda_low | s_sda_low);
  assign sda      = (m_sda_low | s_sda_low) ? 1'b0 : 1'bz;

  pulse_generator u_pulse (
    .clk_i   (clk),
    .rst_i   (reset),
    .send_i  (send),
    .pulse_o (pulse)
  );

  i2c_master #(
    .NUM_OF_FRAMES (NUM_OF_FRAMES),
    .SCL_HALF      (SCL_HALF)
  ) u_master (
    .clk_i     (clk),
    .rst_i     (reset),
    .pulse_i   (pulse),
    .addr_i    (addr2send),
    .rw_i      (r_or_w),
    .data_i    (data2send),
    .sda_i     (sda_line),
    .scl_o     (scl),
    .sda_low_o (m_sda_low),
    .busy_o    (busy)
  );

  i2c_slave #(
    .SLAVE_ADDRESS (SLAVE_ADDRESS)
  ) u_slave (
    .clk_i     (clk),
    .rst_i     (reset),
    .scl_i     (scl),
    .sda_i     (sda_line),
    .sda_low_o (s_sda_low),
    .data_o    (data_received)
  );
endmodule

// File: tb/tb_i2c_link.sv
module tb_i2c_link;
  localparam int unsigned Half = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send = 1'b0;
  logic [6:0] addr2send = 7'h00;
  logic       r_or_w = 1'b0;
  logic [7:0] data2send = 8'h00;
  logic       scl;
  wire        sda;
  logic [7:0] data_received;
  logic       busy;

  pullup (sda);

  always #5 clk = ~clk;

  i2c_link #(
    .NUM_OF_FRAMES (2),
    .SLAVE_ADDRESS (7'h50),
    .SCL_HALF      (Half)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .send          (send),
    .addr2send     (addr2send),
    .r_or_w        (r_or_w),
    .data2send     (data2send),
    .scl           (scl),
    .sda           (sda),
    .data_received (data_received),
    .busy          (busy)
  );

  // Expected bus transaction: scl-rise samples from START to STOP (incl. the STOP rise).
  typedef struct {
    int unsigned nbits;
    logic [31:0] bits;
    logic [7:0]  rx;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_stops  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push_write(input logic [7:0] d);
    exp_t e;
    e.nbits = 19;
    e.bits  = {13'b0, 7'h50, 1'b0, 1'b0, d, 1'b0, 1'b0};
    e.rx    = d;
    exp_q.push_back(e);
  endtask

  task automatic do_send(input logic [6:0] a, input logic [7:0] d, input int unsigned hold);
    @(negedge clk);
    addr2send = a;
    r_or_w    = 1'b0;
    data2send = d;
    send      = 1'b1;
    repeat (hold) @(negedge clk);
    send = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int unsigned n = 0;
    logic seen = 1'b0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    seen = busy;
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_started"}, {31'b0, seen}, 32'd1);
    check({name, "_done"}, {31'b0, busy}, 32'd0);
  endtask

  // Bus monitor: decodes START / bits / STOP and scores each finished transaction.
  initial begin
    logic        pscl = 1'b1;
    logic        psda = 1'b1;
    logic        in_tx = 1'b0;
    int unsigned nb = 0;
    logic [31:0] bits = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_tx = 1'b0;
      end else if (scl && pscl && psda && !sda) begin
        in_tx = 1'b1;
        nb    = 0;
        bits  = '0;
      end else if (scl && !pscl && in_tx) begin
        bits = {bits[30:0], sda};
        nb++;
      end else if (scl && pscl && !psda && sda && in_tx) begin
        in_tx = 1'b0;
        n_stops++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_tx: got STOP after %0d bits, expected no transaction", nb);
        end else begin
          e = exp_q.pop_front();
          check("bit_count", nb, e.nbits);
          check("bit_stream", bits, e.bits);
          check("data_received", {24'b0, data_received}, {24'b0, e.rx});
          check("busy_after_stop", {31'b0, busy}, 32'd0);
        end
      end
      pscl = scl;
      psda = sda;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no end of test, expected finish before 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    int unsigned stops0;

    // Reset values while reset is held.
    @(negedge clk);
    check("rst_scl", {31'b0, scl}, 32'd1);
    check("rst_sda", {31'b0, sda}, 32'd1);
    check("rst_data", {24'b0, data_received}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Matching write of 0xA5; START shape checked inside the first bit time.
    push_write(8'hA5);
    do_send(7'h50, 8'hA5, 2);
    repeat (58) @(negedge clk);
    check("start_scl", {31'b0, scl}, 32'd1);
    check("start_sda", {31'b0, sda}, 32'd0);
    check("start_busy", {31'b0, busy}, 32'd1);
    wait_done("write_a5");
    repeat (2 * Half) @(negedge clk);

    // Wrong address: NACK, then STOP; data_received keeps 0xA5.
    e.nbits = 10;
    e.bits  = {22'b0, 7'h51, 1'b0, 1'b1, 1'b0};
    e.rx    = 8'hA5;
    exp_q.push_back(e);
    do_send(7'h51, 8'h77, 2);
    wait_done("wrong_addr");
    repeat (2 * Half) @(negedge clk);

    // Three back-to-back writes with two bit times of gap.
    for (int i = 0; i < 3; i++) begin
      push_write(8'h3C);
      do_send(7'h50, 8'h3C, 2);
      wait_done("b2b");
      repeat (4 * Half) @(negedge clk);
    end

    // send held high across and well beyond the transaction: exactly one transaction.
    stops0 = n_stops;
    push_write(8'h96);
    @(negedge clk);
    addr2send = 7'h50;
    data2send = 8'h96;
    send      = 1'b1;
    wait_done("long_send");
    repeat (2500) @(negedge clk);
    check("long_send_count", n_stops - stops0, 32'd1);
    check("long_send_idle", {31'b0, busy}, 32'd0);
    send = 1'b0;
    repeat (2 * Half) @(negedge clk);

    // Reset during the data frame aborts without STOP; the next write completes.
    stops0 = n_stops;
    do_send(7'h50, 8'h5A, 2);
    repeat (1300) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_scl", {31'b0, scl}, 32'd1);
    check("abort_sda", {31'b0, sda}, 32'd1);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_data", {24'b0, data_received}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_no_stop", n_stops - stops0, 32'd0);
    push_write(8'hC3);
    do_send(7'h50, 8'hC3, 2);
    wait_done("after_abort");
    repeat (2 * Half) @(negedge clk);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
